// File: rtl/thread_fetch_sched.sv
// Barrel-thread fetch scheduler: per-thread PC file, round-robin pick over the
// active mask, redirect bypass, and a registered fetch slot for the i_mem port.
module thread_fetch_sched #(
  parameter int unsigned NUM_THREADS  = 4,
  parameter int unsigned PC_WIDTH     = 32,
  parameter int unsigned PC_STEP      = 4,
  parameter int unsigned RESET_STRIDE = 4,
  localparam int unsigned TID_W       = $clog2(NUM_THREADS)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          fetch_en,
  input  logic [NUM_THREADS-1:0]        thread_active,
  input  logic                          redirect_valid,
  input  logic [TID_W-1:0]              redirect_tid,
  input  logic [PC_WIDTH-1:0]           redirect_pc,
  output logic                          fetch_valid,
  output logic [TID_W-1:0]              fetch_tid,
  output logic [NUM_THREADS-1:0]        fetch_onehot,
  output logic [PC_WIDTH-1:0]           fetch_pc,
  output logic [NUM_THREADS*PC_WIDTH-1:0] pc_all
);

  logic [PC_WIDTH-1:0]    pc_q [NUM_THREADS];
  logic [PC_WIDTH-1:0]    pc_d [NUM_THREADS];
  logic [TID_W-1:0]       last_tid_q, last_tid_d;
  logic                   fetch_valid_q, fetch_valid_d;
  logic [TID_W-1:0]       fetch_tid_q, fetch_tid_d;
  logic [NUM_THREADS-1:0] fetch_onehot_q, fetch_onehot_d;
  logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;

  logic                   pick_found;
  logic [TID_W-1:0]       pick_tid;
  logic [TID_W-1:0]       cand_tid;
  logic                   redir_ok;
  logic [PC_WIDTH-1:0]    issue_pc;

  // Out-of-range thread indices (non power-of-two builds) never redirect.
  assign redir_ok = redirect_valid && (32'(redirect_tid) < NUM_THREADS);

  // Round-robin search starting after last_tid; last_tid itself is checked last.
  always_comb begin
    pick_found = 1'b0;
    pick_tid   = '0;
    cand_tid   = '0;
    for (int unsigned k = 1; k <= NUM_THREADS; k++) begin
      cand_tid = TID_W'((32'(last_tid_q) + k) % NUM_THREADS);
      if (!pick_found && thread_active[cand_tid]) begin
        pick_found = 1'b1;
        pick_tid   = cand_tid;
      end
    end
  end

  // Next-state: redirect write first, then the issuing thread's bypass/increment.
  always_comb begin
    pc_d           = pc_q;
    last_tid_d     = last_tid_q;
    fetch_valid_d  = 1'b0;
    fetch_onehot_d = '0;
    fetch_tid_d    = fetch_tid_q;
    fetch_pc_d     = fetch_pc_q;
    issue_pc       = '0;

    if (redir_ok) begin
      pc_d[redirect_tid] = redirect_pc;
    end

    if (fetch_en && pick_found) begin
      issue_pc       = (redir_ok && (redirect_tid == pick_tid)) ? redirect_pc : pc_q[pick_tid];
      fetch_valid_d  = 1'b1;
      fetch_tid_d    = pick_tid;
      fetch_onehot_d = NUM_THREADS'(1) << pick_tid;
      fetch_pc_d     = issue_pc;
      last_tid_d     = pick_tid;
      pc_d[pick_tid] = issue_pc + PC_WIDTH'(PC_STEP);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_THREADS; i++) begin
        pc_q[i] <= PC_WIDTH'(i * RESET_STRIDE);
      end
      last_tid_q     <= TID_W'(NUM_THREADS - 1);
      fetch_valid_q  <= 1'b0;
      fetch_tid_q    <= '0;
      fetch_onehot_q <= '0;
      fetch_pc_q     <= '0;
    end else begin
      pc_q           <= pc_d;
      last_tid_q     <= last_tid_d;
      fetch_valid_q  <= fetch_valid_d;
      fetch_tid_q    <= fetch_tid_d;
      fetch_onehot_q <= fetch_onehot_d;
      fetch_pc_q     <= fetch_pc_d;
    end
  end

  assign fetch_valid  = fetch_valid_q;
  assign fetch_tid    = fetch_tid_q;
  assign fetch_onehot = fetch_onehot_q;
  assign fetch_pc     = fetch_pc_q;

  // Flatten the PC file for debug/observation.
  for (genvar g = 0; g < NUM_THREADS; g++) begin : g_pc_all
    assign pc_all[g*PC_WIDTH +: PC_WIDTH] = pc_q[g];
  end

endmodule

// File: tb/tb_thread_fetch_sched.sv
// Directed bench for thread_fetch_sched: 4-thread, 8-thread and 5-thread builds.
module tb_thread_fetch_sched;

  logic        clk;
  logic        reset_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  // 4-thread instance
  logic [3:0]   act4;
  logic [1:0]   rtid4;
  logic         fv4;
  logic [1:0]   ftid4;
  logic [3:0]   foh4;
  logic [31:0]  fpc4;
  logic [127:0] pcall4;

  // 8-thread instance
  logic [7:0]   act8;
  logic [2:0]   rtid8;
  logic         fv8;
  logic [2:0]   ftid8;
  logic [7:0]   foh8;
  logic [31:0]  fpc8;
  logic [255:0] pcall8;

  // 5-thread instance (shares act8[4:0] and rtid8)
  logic         fv5;
  logic [2:0]   ftid5;
  logic [4:0]   foh5;
  logic [31:0]  fpc5;
  logic [159:0] pcall5;

  int checks;
  int fails;

  thread_fetch_sched #(.NUM_THREADS(4)) dut (
    .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en), .thread_active(act4),
    .redirect_valid(redirect_valid), .redirect_tid(rtid4), .redirect_pc(redirect_pc),
    .fetch_valid(fv4), .fetch_tid(ftid4), .fetch_onehot(foh4), .fetch_pc(fpc4),
    .pc_all(pcall4)
  );

  thread_fetch_sched #(.NUM_THREADS(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en), .thread_active(act8),
    .redirect_valid(redirect_valid), .redirect_tid(rtid8), .redirect_pc(redirect_pc),
    .fetch_valid(fv8), .fetch_tid(ftid8), .fetch_onehot(foh8), .fetch_pc(fpc8),
    .pc_all(pcall8)
  );

  thread_fetch_sched #(.NUM_THREADS(5)) dut5 (
    .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en), .thread_active(act8[4:0]),
    .redirect_valid(redirect_valid), .redirect_tid(rtid8), .redirect_pc(redirect_pc),
    .fetch_valid(fv5), .fetch_tid(ftid5), .fetch_onehot(foh5), .fetch_pc(fpc5),
    .pc_all(pcall5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    redirect_valid = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; fetch_en = 1'b1; act4 = 4'hF; act8 = 8'hFF;
    redirect_valid = 1'b1; rtid4 = 2'd1; rtid8 = 3'd1; redirect_pc = 32'h999;
    tick(); tick();
    checks++; if (fv4 !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", fv4); end
    checks++; if (ftid4 !== 2'd0) begin fails++; $display("FAIL reset_tid got %0d exp 0", ftid4); end
    checks++; if (foh4 !== 4'h0) begin fails++; $display("FAIL reset_onehot got %h exp 0", foh4); end
    checks++; if (fpc4 !== 32'h0) begin fails++; $display("FAIL reset_pc got %h exp 0", fpc4); end
    checks++;
    if (pcall4 !== {32'hC, 32'h8, 32'h4, 32'h0}) begin
      fails++; $display("FAIL reset_pc_all got %h exp 0000000c000000080000000400000000", pcall4);
    end
    redirect_valid = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_tid [8];
    logic [31:0] exp_pc  [8];
    exp_tid = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    exp_pc  = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h4, 32'h8, 32'hC, 32'h10};
    do_reset();
    act4 = 4'hF; fetch_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (fv4 !== 1'b1 || ftid4 !== exp_tid[i] || fpc4 !== exp_pc[i] ||
          foh4 !== (4'h1 << exp_tid[i])) begin
        fails++;
        $display("FAIL rr_cycle%0d got v=%b tid=%0d pc=%h oh=%h exp v=1 tid=%0d pc=%h",
                 i, fv4, ftid4, fpc4, foh4, exp_tid[i], exp_pc[i]);
      end
    end
    checks++;
    if (pcall4 !== {32'h14, 32'h10, 32'hC, 32'h8}) begin
      fails++; $display("FAIL rr_pc_all got %h exp 00000014000000100000000c00000008", pcall4);
    end
  endtask

  task automatic test_mask();
    logic [1:0]  exp_tid [4];
    logic [31:0] exp_pc  [4];
    exp_tid = '{2'd1, 2'd3, 2'd1, 2'd3};
    exp_pc  = '{32'h4, 32'hC, 32'h8, 32'h10};
    do_reset();
    act4 = 4'b1010; fetch_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (fv4 !== 1'b1 || ftid4 !== exp_tid[i] || fpc4 !== exp_pc[i]) begin
        fails++;
        $display("FAIL mask_cycle%0d got tid=%0d pc=%h exp tid=%0d pc=%h",
                 i, ftid4, fpc4, exp_tid[i], exp_pc[i]);
      end
    end
    act4 = 4'b0000;
    tick(); tick();
    checks++;
    if (fv4 !== 1'b0 || foh4 !== 4'h0 || ftid4 !== 2'd3 || fpc4 !== 32'h10) begin
      fails++;
      $display("FAIL mask_none got v=%b oh=%h tid=%0d pc=%h exp v=0 oh=0 tid=3 pc=10",
               fv4, foh4, ftid4, fpc4);
    end
    checks++;
    if (pcall4 !== {32'h14, 32'h8, 32'hC, 32'h0}) begin
      fails++; $display("FAIL mask_pc_all got %h exp 00000014000000080000000c00000000", pcall4);
    end
  endtask

  task automatic test_redirect_collision();
    do_reset();
    act4 = 4'hF; fetch_en = 1'b1;
    tick(); tick();
    redirect_valid = 1'b1; rtid4 = 2'd2; redirect_pc = 32'h100;
    tick();
    checks++;
    if (ftid4 !== 2'd2 || fpc4 !== 32'h100 || pcall4[64 +: 32] !== 32'h104) begin
      fails++;
      $display("FAIL redir_collide got tid=%0d pc=%h pc2=%h exp tid=2 pc=100 pc2=104",
               ftid4, fpc4, pcall4[64 +: 32]);
    end
    redirect_valid = 1'b0;
    tick();
    checks++;
    if (ftid4 !== 2'd3 || fpc4 !== 32'hC) begin
      fails++; $display("FAIL redir_after got tid=%0d pc=%h exp tid=3 pc=c", ftid4, fpc4);
    end
    redirect_valid = 1'b1; rtid4 = 2'd1; redirect_pc = 32'h300;
    tick();
    checks++;
    if (ftid4 !== 2'd0 || fpc4 !== 32'h4 || pcall4[32 +: 32] !== 32'h300) begin
      fails++;
      $display("FAIL redir_other got tid=%0d pc=%h pc1=%h exp tid=0 pc=4 pc1=300",
               ftid4, fpc4, pcall4[32 +: 32]);
    end
    redirect_valid = 1'b0;
    tick();
    checks++;
    if (ftid4 !== 2'd1 || fpc4 !== 32'h300) begin
      fails++; $display("FAIL redir_other_issue got tid=%0d pc=%h exp tid=1 pc=300", ftid4, fpc4);
    end
  endtask

  task automatic test_redirect_disabled();
    do_reset();
    act4 = 4'hF; fetch_en = 1'b0;
    redirect_valid = 1'b1; rtid4 = 2'd0; redirect_pc = 32'h200;
    tick();
    checks++;
    if (fv4 !== 1'b0 || fpc4 !== 32'h0 || pcall4[0 +: 32] !== 32'h200) begin
      fails++;
      $display("FAIL redir_disabled got v=%b pc=%h pc0=%h exp v=0 pc=0 pc0=200",
               fv4, fpc4, pcall4[0 +: 32]);
    end
    redirect_valid = 1'b0; fetch_en = 1'b1;
    tick();
    checks++;
    if (fv4 !== 1'b1 || ftid4 !== 2'd0 || fpc4 !== 32'h200) begin
      fails++; $display("FAIL redir_enable got v=%b tid=%0d pc=%h exp v=1 tid=0 pc=200", fv4, ftid4, fpc4);
    end
    fetch_en = 1'b0;
    tick();
    checks++;
    if (fv4 !== 1'b0 || foh4 !== 4'h0 || ftid4 !== 2'd0 || fpc4 !== 32'h200 ||
        pcall4 !== {32'hC, 32'h8, 32'h4, 32'h204}) begin
      fails++;
      $display("FAIL hold_disabled got v=%b oh=%h tid=%0d pc=%h pcall=%h", fv4, foh4, ftid4, fpc4, pcall4);
    end
    fetch_en = 1'b1;
    tick();
    checks++;
    if (ftid4 !== 2'd1 || fpc4 !== 32'h4) begin
      fails++; $display("FAIL resume got tid=%0d pc=%h exp tid=1 pc=4", ftid4, fpc4);
    end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    act4 = 4'hF; fetch_en = 1'b1;
    tick(); tick(); tick();
    redirect_valid = 1'b1; rtid4 = 2'd3; redirect_pc = 32'hFFFF_FFFC;
    tick();
    checks++;
    if (ftid4 !== 2'd3 || fpc4 !== 32'hFFFF_FFFC || pcall4[96 +: 32] !== 32'h0) begin
      fails++;
      $display("FAIL wrap got tid=%0d pc=%h pc3=%h exp tid=3 pc=fffffffc pc3=0",
               ftid4, fpc4, pcall4[96 +: 32]);
    end
    redirect_valid = 1'b0;
    tick();
    checks++;
    if (ftid4 !== 2'd0 || fpc4 !== 32'h4) begin
      fails++; $display("FAIL wrap_next got tid=%0d pc=%h exp tid=0 pc=4", ftid4, fpc4);
    end
    reset_n = 1'b0;
    tick();
    checks++;
    if (fv4 !== 1'b0 || ftid4 !== 2'd0 || foh4 !== 4'h0 || fpc4 !== 32'h0 ||
        pcall4 !== {32'hC, 32'h8, 32'h4, 32'h0}) begin
      fails++;
      $display("FAIL midreset got v=%b tid=%0d oh=%h pc=%h pcall=%h", fv4, ftid4, foh4, fpc4, pcall4);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (fv4 !== 1'b1 || ftid4 !== 2'd0 || fpc4 !== 32'h0 || foh4 !== 4'h1) begin
      fails++; $display("FAIL post_reset got v=%b tid=%0d pc=%h exp v=1 tid=0 pc=0", fv4, ftid4, fpc4);
    end
  endtask

  task automatic test_eight_threads();
    do_reset();
    act8 = 8'hFF; fetch_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (fv8 !== 1'b1 || ftid8 !== 3'(i) || fpc8 !== 32'(4 * i)) begin
        fails++;
        $display("FAIL n8_cycle%0d got tid=%0d pc=%h exp tid=%0d pc=%h", i, ftid8, fpc8, i, 4 * i);
      end
    end
    tick();
    checks++;
    if (ftid8 !== 3'd0 || fpc8 !== 32'h4) begin
      fails++; $display("FAIL n8_wrap got tid=%0d pc=%h exp tid=0 pc=4", ftid8, fpc8);
    end
    redirect_valid = 1'b1; rtid8 = 3'd7; redirect_pc = 32'h500;
    tick();
    checks++;
    if (ftid8 !== 3'd1 || fpc8 !== 32'h8 || pcall8[224 +: 32] !== 32'h500) begin
      fails++;
      $display("FAIL n8_redir got tid=%0d pc=%h pc7=%h exp tid=1 pc=8 pc7=500",
               ftid8, fpc8, pcall8[224 +: 32]);
    end
    redirect_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    tick();
    checks++;
    if (ftid8 !== 3'd7 || fpc8 !== 32'h500) begin
      fails++; $display("FAIL n8_redir_issue got tid=%0d pc=%h exp tid=7 pc=500", ftid8, fpc8);
    end
  endtask

  task automatic test_out_of_range();
    do_reset();
    act8 = 8'hFF; fetch_en = 1'b0;
    redirect_valid = 1'b1; rtid8 = 3'd5; redirect_pc = 32'h700;
    tick();
    rtid8 = 3'd7;
    tick();
    checks++;
    if (pcall5 !== {32'h10, 32'hC, 32'h8, 32'h4, 32'h0}) begin
      fails++; $display("FAIL n5_oor got %h exp 000000100000000c000000080000000400000000", pcall5);
    end
    rtid8 = 3'd4;
    tick();
    checks++;
    if (pcall5[128 +: 32] !== 32'h700) begin
      fails++; $display("FAIL n5_redir got pc4=%h exp 700", pcall5[128 +: 32]);
    end
    redirect_valid = 1'b0; fetch_en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    tick();
    checks++;
    if (ftid5 !== 3'd4 || fpc5 !== 32'h700 || foh5 !== 5'h10) begin
      fails++; $display("FAIL n5_last got tid=%0d pc=%h oh=%h exp tid=4 pc=700 oh=10", ftid5, fpc5, foh5);
    end
    tick();
    checks++;
    if (ftid5 !== 3'd0 || fpc5 !== 32'h4) begin
      fails++; $display("FAIL n5_wrap got tid=%0d pc=%h exp tid=0 pc=4", ftid5, fpc5);
    end
  endtask

  initial begin
    checks = 0; fails = 0;
    reset_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    act4 = '0; rtid4 = '0; act8 = '0; rtid8 = '0;
    test_reset();
    test_round_robin();
    test_mask();
    test_redirect_collision();
    test_redirect_disabled();
    test_wrap_and_reset();
    test_eight_threads();
    test_out_of_range();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
